// File: rtl/rom_dl_ctrl.sv
// ROM download front-end: decodes the ioctl byte stream into CPU/sprite SDRAM writes and PROM strobes,
// buffers SDRAM writes in a small FIFO and issues them one at a time on toggle req/ack ports.
module rom_dl_ctrl #(
   parameter int         FIFO_DEPTH  = 4,
   parameter int         ACK_TIMEOUT = 255,
   parameter logic [7:0] ROM_INDEX   = 8'd0
)(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        prom_wr,
   output logic [9:0]  prom_addr,
   output logic [7:0]  prom_data,
   output logic        rom_loaded,
   output logic        dl_err
);

   localparam int               AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]      WAIT_CNT = (AW+1)'(FIFO_DEPTH-1);
   localparam logic [15:0]      TMO_CNT  = 16'(ACK_TIMEOUT-1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, next;
   logic          wr_p0, dl_p0;
   logic          accept, is_p1, is_p2, is_prom, push, do_push, pop, timeout, full;
   logic [23:0]   s;
   logic [41:0]   entry, head;
   logic [41:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [15:0]   timer;
   logic          sel, ack_sel, req_sel, rom_active;

   // Decode stage: classify the accepted byte and build its FIFO entry
   always_comb begin
      accept  = ioctl_wr & ~wr_p0 & ioctl_download & (ioctl_index == ROM_INDEX);
      s       = ioctl_addr[23:0] - 24'h010000;
      is_p1   = ioctl_addr < 25'h0010000;
      is_p2   = (ioctl_addr >= 25'h0010000) && (ioctl_addr < 25'h001C000);
      is_prom = (ioctl_addr >= 25'h001C000) && (ioctl_addr < 25'h001C320);
      if (is_p1)
         entry = {1'b0, ioctl_addr[23:1], ioctl_addr[0], ~ioctl_addr[0], ioctl_dout, ioctl_dout};
      else
         entry = {1'b1, s[23:16], s[13:0], s[15], s[14], ~s[14], ioctl_dout, ioctl_dout};
   end

   assign full       = (count == FULL_CNT);
   assign push       = accept & (is_p1 | is_p2);
   assign do_push    = push & (~full | pop);
   assign ioctl_wait = (count >= WAIT_CNT);
   assign head       = mem[rd_ptr];
   assign ack_sel    = sel ? port2_ack : port1_ack;
   assign req_sel    = sel ? port2_req : port1_req;

   always_comb begin
      next    = state;
      pop     = 1'b0;
      timeout = 1'b0;
      case (state)
         IDLE:  if (count != '0) next = ISSUE;
         ISSUE: begin
            pop  = 1'b1;
            next = WAIT;
         end
         WAIT: begin
            if (ack_sel == req_sel) next = IDLE;
            else if (timer == TMO_CNT) begin
               timeout = 1'b1;
               next    = IDLE;
            end
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys)
      if (do_push) mem[wr_ptr] <= entry;

   // Issue stage: FIFO bookkeeping, port handshake, status flags
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         wr_p0      <= 1'b0;
         dl_p0      <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         timer      <= '0;
         sel        <= 1'b0;
         port1_req  <= port1_ack;
         port2_req  <= port2_ack;
         port1_a    <= '0;
         port1_ds   <= '0;
         port1_d    <= '0;
         port2_a    <= '0;
         port2_ds   <= '0;
         port2_d    <= '0;
         prom_wr    <= 1'b0;
         prom_addr  <= '0;
         prom_data  <= '0;
         rom_loaded <= 1'b0;
         rom_active <= 1'b0;
         dl_err     <= 1'b0;
      end else begin
         state   <= next;
         wr_p0   <= ioctl_wr;
         dl_p0   <= ioctl_download;
         prom_wr <= accept & is_prom;
         if (accept & is_prom) begin
            prom_addr <= ioctl_addr[9:0];
            prom_data <= ioctl_dout;
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push & ~pop)      count <= count + 1'b1;
         else if (pop & ~do_push) count <= count - 1'b1;
         if (push & ~do_push) dl_err <= 1'b1;
         if (pop) begin
            sel   <= head[41];
            timer <= '0;
            if (head[41]) begin
               {port2_a, port2_ds, port2_d} <= head[40:0];
               port2_req <= ~port2_req;
            end else begin
               {port1_a, port1_ds, port1_d} <= head[40:0];
               port1_req <= ~port1_req;
            end
         end else if (state == WAIT) begin
            timer <= timer + 1'b1;
         end
         // Abandon the write: bring req back in line with ack so no request stays pending
         if (timeout) begin
            dl_err <= 1'b1;
            if (sel) port2_req <= port2_ack;
            else     port1_req <= port1_ack;
         end
         if (ioctl_download & ~dl_p0 & (ioctl_index == ROM_INDEX)) begin
            rom_loaded <= 1'b0;
            rom_active <= 1'b1;
         end else if (rom_active & ~ioctl_download & (count == '0) & (state == IDLE)) begin
            rom_loaded <= 1'b1;
            rom_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl: ack responders, a write logger per port and a PROM strobe monitor.
module tb_rom_dl_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download, ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout, ioctl_index;
   logic        ioctl_wait;
   logic        port1_req, port1_ack, port2_req, port2_ack;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic        prom_wr;
   logic [9:0]  prom_addr;
   logic [7:0]  prom_data;
   logic        rom_loaded, dl_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic        ack_en1, ack_en2;
   int          dly1, dly2;
   logic        last1, last2;
   logic [41:0] log_q[$];
   int          prom_cnt;
   logic [9:0]  prom_last_a;
   logic [7:0]  prom_last_d;
   int          base;

   always #5 clk = ~clk;

   rom_dl_ctrl dut (
      .clk_sys(clk), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
      .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
      .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
      .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_data(prom_data),
      .rom_loaded(rom_loaded), .dl_err(dl_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Acknowledge each request three cycles after it appears
   always @(negedge clk) begin
      if (ack_en1 && port1_req !== port1_ack) begin
         if (dly1 == 2) begin port1_ack = port1_req; dly1 = 0; end
         else dly1++;
      end else dly1 = 0;
      if (ack_en2 && port2_req !== port2_ack) begin
         if (dly2 == 2) begin port2_ack = port2_req; dly2 = 0; end
         else dly2++;
      end else dly2 = 0;
   end

   // A req edge that leaves req != ack is a new write; the resync after timeout is not
   always @(negedge clk) begin
      if (reset) begin
         last1 = port1_req;
         last2 = port2_req;
      end else begin
         if (port1_req !== last1) begin
            if (port1_req !== port1_ack) log_q.push_back({1'b0, port1_a, port1_ds, port1_d});
            last1 = port1_req;
         end
         if (port2_req !== last2) begin
            if (port2_req !== port2_ack) log_q.push_back({1'b1, port2_a, port2_ds, port2_d});
            last2 = port2_req;
         end
         if (prom_wr === 1'b1) begin
            prom_cnt++;
            prom_last_a = prom_addr;
            prom_last_d = prom_data;
         end
      end
   end

   task automatic send(input logic [24:0] a, input logic [7:0] b);
      int n;
      n = 0;
      while (ioctl_wait === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("wait_bound", 64'd1, 64'd0);
      ioctl_addr = a;
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'd0;
      port1_ack = 1'b1; port2_ack = 1'b0;
      ack_en1 = 1'b0; ack_en2 = 1'b0; dly1 = 0; dly2 = 0;
      prom_cnt = 0; prom_last_a = '0; prom_last_d = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // T1 reset state
      check("t1_p1_req", port1_req, 1'b1);
      check("t1_p2_req", port2_req, 1'b0);
      check("t1_wait", ioctl_wait, 1'b0);
      check("t1_prom_wr", prom_wr, 1'b0);
      check("t1_loaded", rom_loaded, 1'b0);
      check("t1_err", dl_err, 1'b0);
      check("t1_p1_bus", {port1_a, port1_ds, port1_d}, 41'd0);
      check("t1_p2_bus", {port2_a, port2_ds, port2_d}, 41'd0);
      repeat (5) @(negedge clk);
      check("t1_no_txn", log_q.size(), 0);
      ack_en1 = 1'b1; ack_en2 = 1'b1;

      // T2 port1 byte lanes, in order
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      @(negedge clk);
      send(25'h0000000, 8'h12);
      send(25'h0000001, 8'h34);
      repeat (20) @(negedge clk);
      check("t2_count", log_q.size(), 2);
      check("t2_w0", log_q[0], {1'b0, 23'h0, 2'b01, 16'h1212});
      check("t2_w1", log_q[1], {1'b0, 23'h0, 2'b10, 16'h3434});

      // T3 port2 interleave: S=0x4003 -> a=6, lane from S[14]; S=0x8000 -> a=1
      send(25'h0014003, 8'hAB);
      send(25'h0018000, 8'hCD);
      repeat (20) @(negedge clk);
      check("t3_count", log_q.size(), 4);
      check("t3_w0", log_q[2], {1'b1, 23'h6, 2'b10, 16'hABAB});
      check("t3_w1", log_q[3], {1'b1, 23'h1, 2'b01, 16'hCDCD});

      // T4 PROM strobe and out-of-range discard
      send(25'h001C305, 8'h5C);
      check("t4_prom_cnt", prom_cnt, 1);
      check("t4_prom_addr", prom_last_a, 10'h305);
      check("t4_prom_data", prom_last_d, 8'h5C);
      send(25'h001C320, 8'h11);
      repeat (20) @(negedge clk);
      check("t4_discard_prom", prom_cnt, 1);
      check("t4_discard_fifo", log_q.size(), 4);
      check("t4_no_err", dl_err, 1'b0);

      // T5 ack withheld: backpressure, timeouts, every entry still issued
      ack_en1 = 1'b0;
      base = log_q.size();
      for (int i = 0; i < 4; i++) send(25'h100 + 25'(i), 8'h50 + 8'(i));
      check("t5_wait_high", ioctl_wait, 1'b1);
      send(25'h104, 8'h54);
      send(25'h105, 8'h55);
      for (int n = 0; n < 3000 && log_q.size() < base + 6; n++) @(negedge clk);
      check("t5_issued", log_q.size(), base + 6);
      check("t5_err", dl_err, 1'b1);
      for (int i = 0; i < 6 && base + i < log_q.size(); i++)
         check("t5_entry", log_q[base+i],
               {1'b0, 23'h80 + 23'(i/2), (i % 2 == 1) ? 2'b10 : 2'b01, {2{8'h50 + 8'(i)}}});
      repeat (300) @(negedge clk);
      ack_en1 = 1'b1;
      check("t5_wait_low", ioctl_wait, 1'b0);

      // T6 rom_loaded only after the final write is acknowledged
      base = log_q.size();
      send(25'h200, 8'h77);
      ioctl_download = 1'b0;
      @(negedge clk);
      check("t6_not_yet", rom_loaded, 1'b0);
      for (int n = 0; n < 200 && rom_loaded !== 1'b1; n++) @(negedge clk);
      check("t6_loaded", rom_loaded, 1'b1);
      check("t6_acked", port1_req, port1_ack);
      check("t6_last", log_q.size() > base ? log_q[base] : 42'd0, {1'b0, 23'h100, 2'b01, 16'h7777});
      ioctl_index = 8'd254; ioctl_download = 1'b1;
      @(negedge clk);
      send(25'h0000000, 8'h99);
      send(25'h001C000, 8'h01);
      ioctl_download = 1'b0;
      repeat (20) @(negedge clk);
      check("t6_other_loaded", rom_loaded, 1'b1);
      check("t6_other_fifo", log_q.size(), base + 1);
      check("t6_other_prom", prom_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
